// File: rtl/mk_design_param.sv
// Parametrised two-queue compute block behind EN/RDY method ports.
// Operand pairs queue up, a MODE-selected op fills a result queue, and check pops with a saturating miss count.
module mk_design_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] start_a,
  input  logic [WIDTH-1:0] start_b,
  input  logic             EN_start,
  output logic             RDY_start,
  input  logic [WIDTH-1:0] result_c,
  output logic [WIDTH-1:0] result,
  output logic             RDY_result,
  input  logic [WIDTH-1:0] check_d,
  input  logic             EN_check,
  output logic             check,
  output logic             RDY_check,
  output logic [CNT_W-1:0] mismatch_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0]    PTR_ONE = AW'(1'b1);
  localparam logic [AW:0]      OCC_ONE = (AW+1)'(1'b1);
  localparam logic [AW:0]      OCC_MAX = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [WIDTH-1:0] op_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] prod;
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    case (MODE)
      32'sd1:  op_f = a - b;
      32'sd2:  op_f = prod[WIDTH-1:0];
      default: op_f = a + b;
    endcase
  endfunction

  logic [WIDTH-1:0] in_a_r [DEPTH];
  logic [WIDTH-1:0] in_b_r [DEPTH];
  logic [WIDTH-1:0] out_r  [DEPTH];
  logic [AW-1:0]    in_wr_r, in_rd_r, out_wr_r, out_rd_r;
  logic [AW:0]      in_cnt_r, out_cnt_r, in_cnt_nx_s, out_cnt_nx_s;
  logic             in_full_r, in_empty_r, out_full_r, out_empty_r;
  logic [CNT_W-1:0] mis_r;
  logic             enq_s, deq_s, xfer_s, check_s;
  logic [WIDTH-1:0] head_s, result_s;

  assign RDY_start      = !in_full_r;
  assign RDY_result     = !out_empty_r;
  assign RDY_check      = !out_empty_r;
  assign result         = result_s;
  assign check          = check_s;
  assign mismatch_count = mis_r;

  // Handshake qualification, transfer enable and the value methods.
  always_comb begin
    enq_s    = EN_start && !in_full_r;
    deq_s    = EN_check && !out_empty_r;
    // A same-cycle pop frees the slot the transfer writes into.
    xfer_s   = !in_empty_r && (!out_full_r || deq_s);
    head_s   = out_r[out_rd_r];
    result_s = '0;
    check_s  = 1'b0;
    if (!out_empty_r) begin
      result_s = head_s + result_c;
      check_s  = (head_s == check_d);
    end else begin
      result_s = '0;
      check_s  = 1'b0;
    end
  end

  // Next occupancy of both queues from push/pop of the current cycle.
  always_comb begin
    in_cnt_nx_s  = in_cnt_r;
    out_cnt_nx_s = out_cnt_r;
    case ({enq_s, xfer_s})
      2'b10:   in_cnt_nx_s = in_cnt_r + OCC_ONE;
      2'b01:   in_cnt_nx_s = in_cnt_r - OCC_ONE;
      default: in_cnt_nx_s = in_cnt_r;
    endcase
    case ({xfer_s, deq_s})
      2'b10:   out_cnt_nx_s = out_cnt_r + OCC_ONE;
      2'b01:   out_cnt_nx_s = out_cnt_r - OCC_ONE;
      default: out_cnt_nx_s = out_cnt_r;
    endcase
  end

  // Pointers, occupancy, registered full/empty flags and the miss counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      in_wr_r     <= '0;
      in_rd_r     <= '0;
      out_wr_r    <= '0;
      out_rd_r    <= '0;
      in_cnt_r    <= '0;
      out_cnt_r   <= '0;
      in_full_r   <= 1'b0;
      in_empty_r  <= 1'b1;
      out_full_r  <= 1'b0;
      out_empty_r <= 1'b1;
      mis_r       <= '0;
    end else begin
      if (enq_s)  in_wr_r  <= in_wr_r + PTR_ONE;
      if (xfer_s) in_rd_r  <= in_rd_r + PTR_ONE;
      if (xfer_s) out_wr_r <= out_wr_r + PTR_ONE;
      if (deq_s)  out_rd_r <= out_rd_r + PTR_ONE;
      in_cnt_r    <= in_cnt_nx_s;
      out_cnt_r   <= out_cnt_nx_s;
      in_full_r   <= (in_cnt_nx_s == OCC_MAX);
      in_empty_r  <= (in_cnt_nx_s == '0);
      out_full_r  <= (out_cnt_nx_s == OCC_MAX);
      out_empty_r <= (out_cnt_nx_s == '0);
      if (deq_s && !check_s && (mis_r != CNT_MAX)) mis_r <= mis_r + CNT_ONE;
    end
  end

  // Queue storage; the computed value is written at transfer time.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        in_a_r[i] <= '0;
        in_b_r[i] <= '0;
        out_r[i]  <= '0;
      end
    end else begin
      if (enq_s) begin
        in_a_r[in_wr_r] <= start_a;
        in_b_r[in_wr_r] <= start_b;
      end
      if (xfer_s) out_r[out_wr_r] <= op_f(in_a_r[in_rd_r], in_b_r[in_rd_r]);
    end
  end

endmodule

// File: tb/tb_mk_design_param.sv
// Bench for mk_design_param: three MODE instances plus a CNT_W=2 instance share one stimulus stream,
// each checked against a per-instance queue model of expected results.
module tb_mk_design_param;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] start_a = 8'h00, start_b = 8'h00, result_c = 8'h00, check_d = 8'h00;
  logic       EN_start = 1'b0, EN_check = 1'b0;
  logic [3:0] rdy_start, rdy_result, rdy_check, chk;
  logic [7:0] res [4];
  logic [7:0] mcnt [3];
  logic [1:0] mcnt3;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq [4][$];
  int         mc [4];
  int         cmax [4] = '{255, 255, 255, 3};
  int         mode_of [4] = '{0, 1, 2, 0};

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_mode
    mk_design_param #(.WIDTH(8), .DEPTH(4), .MODE(g), .CNT_W(8)) u_dut (
      .CLK(CLK), .RST(RST), .start_a(start_a), .start_b(start_b), .EN_start(EN_start),
      .RDY_start(rdy_start[g]), .result_c(result_c), .result(res[g]), .RDY_result(rdy_result[g]),
      .check_d(check_d), .EN_check(EN_check), .check(chk[g]), .RDY_check(rdy_check[g]),
      .mismatch_count(mcnt[g]));
  end

  mk_design_param #(.WIDTH(8), .DEPTH(4), .MODE(0), .CNT_W(2)) u_sat (
    .CLK(CLK), .RST(RST), .start_a(start_a), .start_b(start_b), .EN_start(EN_start),
    .RDY_start(rdy_start[3]), .result_c(result_c), .result(res[3]), .RDY_result(rdy_result[3]),
    .check_d(check_d), .EN_check(EN_check), .check(chk[3]), .RDY_check(rdy_check[3]),
    .mismatch_count(mcnt3));

  function automatic logic [7:0] model_op(input int mode, input logic [7:0] a, input logic [7:0] b);
    int r;
    if (mode == 1)      r = (int'(a) - int'(b) + 256) % 256;
    else if (mode == 2) r = (int'(a) * int'(b)) % 256;
    else                r = (int'(a) + int'(b)) % 256;
    return 8'(r);
  endfunction

  function automatic int get_mcnt(input int i);
    if (i == 3) return int'(mcnt3);
    return int'(mcnt[i]);
  endfunction

  // Update the model with this cycle's handshakes, then advance one clock.
  task automatic cycle();
    for (int i = 0; i < 4; i++) begin
      if (RST) begin
        mq[i].delete();
        mc[i] = 0;
      end else begin
        if (EN_check && rdy_check[i] === 1'b1 && mq[i].size() > 0) begin
          if (mq[i][0] != check_d && mc[i] < cmax[i]) mc[i]++;
          void'(mq[i].pop_front());
        end
        if (EN_start && rdy_start[i] === 1'b1) mq[i].push_back(model_op(mode_of[i], start_a, start_b));
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    EN_start = 1'b0;
    EN_check = 1'b0;
    RST = 1'b1;
    cycle();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    result_c = 8'hA5;
    check_d  = 8'h00;
    RST = 1'b1;
    cycle();
    cycle();
    RST = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({rdy_start[i], rdy_result[i], rdy_check[i], chk[i]} !== 4'b1000) begin
        bad++;
        $display("FAIL reset_flags[%0d] got=%b exp=1000", i, {rdy_start[i], rdy_result[i], rdy_check[i], chk[i]});
      end
      total++;
      if (res[i] !== 8'h00 || get_mcnt(i) != 0) begin
        bad++;
        $display("FAIL reset_values[%0d] result=%0h mcnt=%0d exp 0/0", i, res[i], get_mcnt(i));
      end
    end
  endtask

  task automatic test_single_add();
    start_a = 8'h12; start_b = 8'h34; EN_start = 1'b1;
    cycle();
    EN_start = 1'b0;
    total++;
    if (rdy_result[0] !== 1'b0) begin bad++; $display("FAIL add_t1_rdy got=%b exp=0", rdy_result[0]); end
    cycle();
    result_c = 8'h01; check_d = 8'h46;
    #1;
    total++;
    if (rdy_result[0] !== 1'b1) begin bad++; $display("FAIL add_t2_rdy got=%b exp=1", rdy_result[0]); end
    total++;
    if (res[0] !== 8'h47) begin bad++; $display("FAIL add_result got=%0h exp=47", res[0]); end
    total++;
    if (chk[0] !== 1'b1) begin bad++; $display("FAIL add_check got=%b exp=1", chk[0]); end
    EN_check = 1'b1;
    cycle();
    EN_check = 1'b0;
    total++;
    if (rdy_result[0] !== 1'b0) begin bad++; $display("FAIL add_t3_rdy got=%b exp=0", rdy_result[0]); end
  endtask

  task automatic test_wrap();
    logic [7:0] pa [3] = '{8'hFF, 8'h00, 8'h10};
    logic [7:0] pb [3] = '{8'h02, 8'h01, 8'h11};
    logic [7:0] ph [3] = '{8'h01, 8'hFF, 8'h10};
    for (int p = 0; p < 3; p++) begin
      start_a = pa[p]; start_b = pb[p]; EN_start = 1'b1;
      cycle();
      EN_start = 1'b0;
      cycle();
      result_c = 8'h00; check_d = ph[p];
      #1;
      total++;
      if (res[p] !== ph[p] || chk[p] !== 1'b1) begin
        bad++;
        $display("FAIL wrap_mode%0d got=%0h/%b exp=%0h/1", p, res[p], chk[p], ph[p]);
      end
      EN_check = 1'b1;
      cycle();
      EN_check = 1'b0;
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      total++;
      if (rdy_start[0] !== 1'b1) begin bad++; $display("FAIL fill_rdy_start[%0d] got=%b exp=1", k, rdy_start[0]); end
      start_a = 8'(k); start_b = 8'h00; EN_start = 1'b1;
      cycle();
    end
    EN_start = 1'b0;
    total++;
    if (rdy_start[0] !== 1'b0) begin bad++; $display("FAIL fill_full got=%b exp=0", rdy_start[0]); end
    start_a = 8'h09; EN_start = 1'b1;
    cycle();
    cycle();
    EN_start = 1'b0;
    result_c = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      int w = 0;
      while (rdy_check[0] !== 1'b1 && w < 4) begin cycle(); w++; end
      check_d = 8'(k);
      #1;
      total++;
      if (rdy_check[0] !== 1'b1 || res[0] !== 8'(k)) begin
        bad++;
        $display("FAIL drain_order[%0d] rdy=%b got=%0h exp=%0h", k, rdy_check[0], res[0], k);
      end
      EN_check = 1'b1;
      cycle();
      EN_check = 1'b0;
    end
    cycle();
    cycle();
    total++;
    if (rdy_check[0] !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", rdy_check[0]); end
    total++;
    if (mcnt[0] !== 8'd0) begin bad++; $display("FAIL drain_mcnt got=%0d exp=0", mcnt[0]); end
  endtask

  task automatic test_full_rate();
    int n_ok = 0;
    do_reset();
    EN_start = 1'b1; EN_check = 1'b1; result_c = 8'h00;
    for (int c = 0; c < 20; c++) begin
      start_a = 8'($urandom); start_b = 8'($urandom);
      check_d = (mq[0].size() > 0) ? mq[0][0] : 8'h00;
      #1;
      total++;
      if (rdy_start[0] !== 1'b1) begin bad++; $display("FAIL rate_rdy_start[%0d] got=%b exp=1", c, rdy_start[0]); end
      if (c >= 2) begin
        total++;
        if (rdy_check[0] !== 1'b1 || chk[0] !== 1'b1) begin
          bad++;
          $display("FAIL rate_pop[%0d] rdy=%b check=%b exp 1/1", c, rdy_check[0], chk[0]);
        end
      end
      if (rdy_check[0] === 1'b1 && chk[0] === 1'b1) n_ok++;
      cycle();
    end
    EN_start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check_d = (mq[0].size() > 0) ? mq[0][0] : 8'h00;
      #1;
      if (rdy_check[0] === 1'b1 && chk[0] === 1'b1) n_ok++;
      cycle();
    end
    EN_check = 1'b0;
    total++;
    if (n_ok != 20) begin bad++; $display("FAIL rate_count got=%0d exp=20", n_ok); end
    total++;
    if (mcnt[0] !== 8'd0) begin bad++; $display("FAIL rate_mcnt got=%0d exp=0", mcnt[0]); end
  endtask

  task automatic test_mismatch();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      int n_bad = (r == 0) ? 3 : 5;
      EN_start = 1'b1;
      for (int s = 0; s < 5; s++) begin
        start_a = 8'($urandom); start_b = 8'($urandom);
        cycle();
      end
      EN_start = 1'b0;
      cycle();
      cycle();
      EN_check = 1'b1;
      for (int j = 0; j < n_bad; j++) begin
        check_d = mq[0][0] ^ 8'h01;
        #1;
        total++;
        if (rdy_check[0] !== 1'b1 || chk[0] !== 1'b0) begin
          bad++;
          $display("FAIL miss_pop[%0d] rdy=%b check=%b exp 1/0", j, rdy_check[0], chk[0]);
        end
        cycle();
      end
      EN_check = 1'b0;
      total++;
      if (mcnt[0] !== 8'(n_bad)) begin bad++; $display("FAIL miss_count got=%0d exp=%0d", mcnt[0], n_bad); end
      total++;
      if (mcnt3 !== 2'd3) begin bad++; $display("FAIL miss_sat got=%0d exp=3", mcnt3); end
      if (r == 0) begin
        RST = 1'b1; EN_start = 1'b1; EN_check = 1'b1;
        cycle();
        RST = 1'b0; EN_start = 1'b0; EN_check = 1'b0;
        #1;
        total++;
        if (mcnt[0] !== 8'd0 || rdy_result[0] !== 1'b0 || rdy_start[0] !== 1'b1) begin
          bad++;
          $display("FAIL midreset mcnt=%0d rdy_result=%b rdy_start=%b exp 0/0/1", mcnt[0], rdy_result[0], rdy_start[0]);
        end
        cycle(); cycle(); cycle();
        total++;
        if (rdy_check[0] !== 1'b0) begin bad++; $display("FAIL midreset_gone got=%b exp=0", rdy_check[0]); end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      EN_start = 1'($urandom % 2);
      EN_check = 1'($urandom % 2);
      start_a  = 8'($urandom); start_b = 8'($urandom); result_c = 8'($urandom);
      check_d  = (mq[0].size() > 0 && ($urandom % 2) == 1) ? mq[0][0] : 8'($urandom);
      #1;
      for (int i = 0; i < 4; i++) begin
        logic [7:0] hd;
        total++;
        if (rdy_check[i] === 1'b1) begin
          if (mq[i].size() == 0) begin
            bad++;
            $display("FAIL rand_spurious[%0d] cyc=%0d rdy=1 exp=0", i, c);
          end else begin
            hd = mq[i][0];
            if (res[i] !== 8'(hd + result_c) || chk[i] !== (hd == check_d)) begin
              bad++;
              $display("FAIL rand_value[%0d] cyc=%0d got=%0h/%b exp=%0h/%b", i, c, res[i], chk[i], 8'(hd + result_c), hd == check_d);
            end
          end
        end else if (res[i] !== 8'h00 || chk[i] !== 1'b0) begin
          bad++;
          $display("FAIL rand_idle[%0d] cyc=%0d got=%0h/%b exp=0/0", i, c, res[i], chk[i]);
        end
        total++;
        if (get_mcnt(i) != mc[i]) begin
          bad++;
          $display("FAIL rand_mcnt[%0d] cyc=%0d got=%0d exp=%0d", i, c, get_mcnt(i), mc[i]);
        end
      end
      cycle();
    end
    EN_start = 1'b0;
    EN_check = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_wrap();
    test_fill();
    test_full_rate();
    test_mismatch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mk_design_param.md
# mk_design_param

Parametrised successor to the fixed-width, single-entry method block (`start` / `result` / `check`). Operand pairs are accepted through `start` into an input queue of DEPTH entries. A compute stage applies a MODE-selected operation. Results are held in an output queue, where `result` observes them and `check` consumes them. The block sits behind BSV-style EN/RDY method ports and keeps a saturating count of failed checks for the testbench scoreboard.

## Interface
- WIDTH, 8: operand/result width in bits (≥2)
- DEPTH, 4: entries in each of the input and output queues (power of 2, ≥2)
- MODE, 0: operation; 0 = a+b, 1 = a−b, 2 = low WIDTH bits of a×b
- CNT_W, 8: mismatch counter width

Clocking: one clock; reset is synchronous and active-high.

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous active-high reset
- start_a  in  WIDTH  operand a of `start`
- start_b  in  WIDTH  operand b of `start`
- EN_start  in  1  enqueue {a,b} this cycle
- RDY_start  out  1  input queue not full
- result_c  in  WIDTH  argument of `result`
- result  out  WIDTH  output head + result_c, mod 2^WIDTH (combinational)
- RDY_result  out  1  output queue not empty
- check_d  in  WIDTH  expected value for `check`
- EN_check  in  1  dequeue output head this cycle
- check  out  1  output head == check_d (combinational)
- RDY_check  out  1  output queue not empty (same as RDY_result)
- mismatch_count  out  CNT_W  saturating count of dequeues where check was 0

## Operation
- **Input queue:** circular buffer with DEPTH entries, registered full/empty flags.
  - RDY_start = !in_full, with no same-cycle bypass from transfer.
  - EN_start while RDY_start is 0 is ignored and causes no state change.
- **Transfer/compute:** when the input queue is non-empty and the output queue can accept, the input head is popped in that cycle.
  - Output queue can accept when not full, or when EN_check && RDY_check in the same cycle.
  - op(a,b) per MODE is pushed into the output queue. All arithmetic is mod 2^WIDTH (subtraction wraps; the product is truncated to its low WIDTH bits).
- **Output queue:** circular buffer with DEPTH entries.
  - RDY_result = RDY_check = !out_empty.
  - When RDY is 0: result = 0 and check = 0.
- **check:**
  - EN_check while RDY_check is 1 pops the head.
  - If check == 0 in that cycle, mismatch_count increments, saturating at 2^CNT_W−1.
  - EN_check while RDY_check is 0 is ignored.
- **result:** pure value method; it never pops.
- **Queue order:** strict FIFO; results dequeue in `start` order.
- **Pointers:** wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit or an occupancy counter.
- **Simultaneous events:** enqueue, transfer and dequeue may all occur in one cycle. Occupancies update consistently, with no loss or duplication.

## Timing
- **Reset:** while RST = 1 at a clock edge:
  - both queues are emptied and mismatch_count = 0;
  - EN_start and EN_check in that cycle are ignored.
- **Outputs at reset:** in the cycle after the reset edge, RDY_start = 1, RDY_result = RDY_check = 0, result = 0, check = 0, mismatch_count = 0.
- **Reset mid-operation:** all queued data is discarded with no partial pop; the block behaves as freshly reset.
- **Latency:** EN_start accepted in cycle t with both queues empty gives RDY_result = 1 in cycle t+2.
- **Throughput:** one operation per cycle sustained, with EN_start and EN_check held high.
- **Back-pressure:** with no EN_check, the block accepts exactly 2×DEPTH starts before RDY_start falls.
- **Combinational paths:**
  - result_c → result and check_d → check.
  - EN_check → transfer enable.
  - No path from EN_start to any RDY.

## Test plan
- **Reset values:** assert RST for 2 cycles, then release. Required: RDY_start = 1, RDY_result = 0, RDY_check = 0, result = 0, check = 0, mismatch_count = 0.
- **Single add (WIDTH=8, MODE=0):**
  - Stimulus: start(0x12, 0x34) at cycle t.
  - Required: RDY_result = 1 at t+2; result = 0x47 with result_c = 0x01; check = 1 with check_d = 0x46; EN_check pops; RDY_result = 0 at t+3.
- **Wrap arithmetic:**
  - MODE=0: start(0xFF, 0x02) → head 0x01.
  - MODE=1: start(0x00, 0x01) → head 0xFF.
  - MODE=2: start(0x10, 0x11) → head 0x10.
- **Fill and ordering (DEPTH=4):**
  - Stimulus: 8 starts with a = 1..8, b = 0, no EN_check.
  - Required: RDY_start = 0 after the 8th accept; a 9th EN_start is ignored.
  - Draining yields 1..8 in order, then RDY_check = 0.
- **Simultaneous full-rate:**
  - Stimulus: EN_start and EN_check held high for 20 cycles with matching check_d.
  - Required: no drops and mismatch_count = 0; occupancy stays constant after the 2-cycle fill.
- **Mismatch and reset mid-flight:**
  - Stimulus: 3 checks with wrong check_d, then RST for one cycle with 2 entries queued.
  - Required: mismatch_count = 3 before reset. After reset: mismatch_count = 0, RDY_result = 0, and the queued entries are gone.
  - Repeat with CNT_W = 2: 5 mismatches saturate at 3.
